// File: rtl/decryption_pkg.sv
// Shared constants for the decryption register bank.
// Address map, CTRL/STATUS bit positions and default key reset values.
package decryption_pkg;

    localparam int ADDR_SELECT = 'h00;
    localparam int ADDR_CTRL   = 'h02;
    localparam int ADDR_STATUS = 'h04;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_LOCK   = 1;

    localparam int STAT_PENDING = 0;
    localparam int STAT_LOCKED  = 1;
    localparam int STAT_STICKY  = 2;

    localparam logic [47:0] DEFAULT_KEY_RESET =
        {16'h0002, 16'hFFFF, 16'h0000};

    // Width of the select field: enough bits to name every key.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_shadow_reg.sv
// One shadow/active register pair with write and commit enables.
// Shadowing is built only when CIPHER_KEY_REGFILE_SHADOW_EN is defined.
module key_shadow_reg #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             ce,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] shadow,
    output logic [WIDTH-1:0] active
);

`ifdef CIPHER_KEY_REGFILE_SHADOW_EN
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] active_q;

    // Writes land in shadow; commit copies the pre-edge shadow to active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= RESET_VAL;
            active_q <= RESET_VAL;
        end else begin
            if (we)
                shadow_q <= wdata;
            if (ce)
                active_q <= shadow_q;
        end
    end

    assign shadow = shadow_q;
    assign active = active_q;
`else
    logic [WIDTH-1:0] value_q;
    logic             unused_ce;

    // Single copy: a write is visible on the outputs immediately.
    always_ff @(posedge clk) begin
        if (!rst_n)
            value_q <= RESET_VAL;
        else if (we)
            value_q <= wdata;
    end

    assign shadow    = value_q;
    assign active    = value_q;
    assign unused_ce = ce;
`endif

endmodule

// File: rtl/cipher_key_regfile.sv
// Double-buffered cipher key and select bank for the decryption datapath.
// Shadow/commit path enabled by defining CIPHER_KEY_REGFILE_SHADOW_EN.
module cipher_key_regfile
    import decryption_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_WIDTH  = 16,
    parameter int NUM_KEYS   = 3,
    parameter int KEY_BASE   = 16,
    parameter int KEY_STRIDE = 2,
    parameter logic [NUM_KEYS*REG_WIDTH-1:0] KEY_RESET = DEFAULT_KEY_RESET
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic                          read,
    input  logic                          write,
    input  logic [REG_WIDTH-1:0]          wdata,
    output logic [REG_WIDTH-1:0]          rdata,
    output logic                          done,
    output logic                          error,
    input  logic                          core_busy,
    output logic [REG_WIDTH-1:0]          select,
    output logic [NUM_KEYS*REG_WIDTH-1:0] keys,
    output logic                          commit_done
);

    localparam int SW = sel_width(NUM_KEYS);

    logic [SW-1:0]        sel_shadow;
    logic [SW-1:0]        sel_active;
    logic [REG_WIDTH-1:0] key_shadow [NUM_KEYS];

    logic                 pending_q;
    logic                 locked_q;
    logic                 sticky_q;
    logic                 commit_fire;

    logic                 strobe;
    logic                 hit_sel;
    logic                 hit_ctrl;
    logic                 hit_stat;
    logic                 hit_key;
    logic [NUM_KEYS-1:0]  key_sel;
    logic [REG_WIDTH-1:0] key_rd;
    logic [REG_WIDTH-1:0] status_val;

    logic                 acc_err;
    logic [REG_WIDTH-1:0] rd_val;
    logic                 sel_we;
    logic [NUM_KEYS-1:0]  key_we;
    logic                 lock_set;
    logic                 commit_req;
    logic                 status_rd;

    assign strobe   = read | write;
    assign hit_sel  = (addr == ADDR_WIDTH'(ADDR_SELECT));
    assign hit_ctrl = (addr == ADDR_WIDTH'(ADDR_CTRL));
    assign hit_stat = (addr == ADDR_WIDTH'(ADDR_STATUS));

    // Find which key slot (if any) the address points at.
    always_comb begin
        key_sel = '0;
        key_rd  = '0;
        hit_key = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (addr == ADDR_WIDTH'(KEY_BASE + i * KEY_STRIDE)) begin
                key_sel[i] = 1'b1;
                key_rd     = key_shadow[i];
                hit_key    = 1'b1;
            end
        end
    end

    // Assemble the STATUS word from its flag registers.
    always_comb begin
        status_val               = '0;
        status_val[STAT_PENDING] = pending_q;
        status_val[STAT_LOCKED]  = locked_q;
        status_val[STAT_STICKY]  = sticky_q;
    end

    // Decode one bus access into register enables and a verdict.
    always_comb begin
        acc_err    = 1'b0;
        rd_val     = '0;
        sel_we     = 1'b0;
        key_we     = '0;
        lock_set   = 1'b0;
        commit_req = 1'b0;
        status_rd  = 1'b0;
        if (strobe) begin
            if (read && write) begin
                acc_err = 1'b1;
            end else begin
                unique case (1'b1)
                    hit_sel: begin
                        if (read)
                            rd_val = REG_WIDTH'(sel_shadow);
                        else if (locked_q ||
                                 wdata >= REG_WIDTH'(NUM_KEYS))
                            acc_err = 1'b1;
                        else
                            sel_we = 1'b1;
                    end
                    hit_ctrl: begin
                        if (write) begin
                            if (locked_q && !wdata[CTRL_LOCK]) begin
                                acc_err = 1'b1;
                            end else begin
                                lock_set   = wdata[CTRL_LOCK];
                                commit_req = wdata[CTRL_COMMIT];
                            end
                        end
                    end
                    hit_stat: begin
                        if (read) begin
                            rd_val    = status_val;
                            status_rd = 1'b1;
                        end else begin
                            acc_err = 1'b1;
                        end
                    end
                    hit_key: begin
                        if (read)
                            rd_val = key_rd;
                        else if (locked_q)
                            acc_err = 1'b1;
                        else
                            key_we = key_sel;
                    end
                    default: acc_err = 1'b1;
                endcase
            end
        end
    end

    // Bus response, lock bit and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            locked_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            done  <= strobe;
            error <= acc_err;
            if (read)
                rdata <= acc_err ? '0 : rd_val;
            if (lock_set)
                locked_q <= 1'b1;
            if (acc_err)
                sticky_q <= 1'b1;
            else if (status_rd)
                sticky_q <= 1'b0;
        end
    end

`ifdef CIPHER_KEY_REGFILE_SHADOW_EN
    assign commit_fire = pending_q && !core_busy;

    // Pending commit waits for the core to go idle, then pulses done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q   <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            commit_done <= commit_fire;
            if (commit_fire)
                pending_q <= 1'b0;
            else if (commit_req)
                pending_q <= 1'b1;
        end
    end
`else
    logic unused_commit;

    assign commit_fire   = 1'b0;
    assign pending_q     = 1'b0;
    assign commit_done   = 1'b0;
    assign unused_commit = commit_req ^ core_busy;
`endif

    key_shadow_reg #(
        .WIDTH     (SW),
        .RESET_VAL ('0)
    ) u_sel (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (sel_we),
        .ce     (commit_fire),
        .wdata  (wdata[SW-1:0]),
        .shadow (sel_shadow),
        .active (sel_active)
    );

    assign select = REG_WIDTH'(sel_active);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_shadow_reg #(
            .WIDTH     (REG_WIDTH),
            .RESET_VAL (KEY_RESET[g*REG_WIDTH +: REG_WIDTH])
        ) u_key (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (key_we[g]),
            .ce     (commit_fire),
            .wdata  (wdata),
            .shadow (key_shadow[g]),
            .active (keys[g*REG_WIDTH +: REG_WIDTH])
        );
    end

endmodule

// File: tb/tb_cipher_key_regfile.sv
// Randomized bench for cipher_key_regfile against a behavioural model.
// Follows CIPHER_KEY_REGFILE_SHADOW_EN the same way as the design.
module tb_cipher_key_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  addr = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        done;
    logic        error;
    logic        core_busy = 1'b0;
    logic [15:0] select;
    logic [47:0] keys;
    logic        commit_done;

    int n_checks = 0;
    int n_errors = 0;

    cipher_key_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .read        (read),
        .write       (write),
        .wdata       (wdata),
        .rdata       (rdata),
        .done        (done),
        .error       (error),
        .core_busy   (core_busy),
        .select      (select),
        .keys        (keys),
        .commit_done (commit_done)
    );

    always #5 clk = ~clk;

    // Reference state: shadow and active copies as plain arrays.
    logic [15:0] m_sh [3];
    logic [15:0] m_act [3];
    int          m_sel_sh, m_sel_act;
    bit          m_pend, m_lock, m_sticky;
    logic [15:0] m_rdata;
    bit          m_done, m_err, m_cd;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sh[0] = 16'h0000; m_sh[1] = 16'hFFFF; m_sh[2] = 16'h0002;
        m_act = m_sh;
        m_sel_sh = 0; m_sel_act = 0;
        m_pend = 0; m_lock = 0; m_sticky = 0;
        m_rdata = 0; m_done = 0; m_err = 0; m_cd = 0;
    endtask

    task automatic model_edge(input bit rd, input bit wr, input int a,
                              input logic [15:0] d, input bit busy);
        bit          err = 0;
        bit          req = 0;
        bit          stat_rd = 0;
        logic [15:0] rv = 0;
        logic [15:0] old_sh [3];
        int          old_sel;
        int          ki = -1;
        old_sh = m_sh;
        old_sel = m_sel_sh;
        for (int k = 0; k < 3; k++)
            if (a == 16 + 2 * k) ki = k;
        if (rd || wr) begin
            if (rd && wr) err = 1;
            else if (a == 0) begin
                if (rd) rv = 16'(m_sel_sh);
                else if (m_lock || d >= 3) err = 1;
                else begin
                    m_sel_sh = int'(d);
`ifndef CIPHER_KEY_REGFILE_SHADOW_EN
                    m_sel_act = int'(d);
`endif
                end
            end else if (a == 2) begin
                if (wr) begin
                    if (m_lock && !d[1]) err = 1;
                    else begin
                        if (d[1]) m_lock = 1;
                        req = d[0];
                    end
                end
            end else if (a == 4) begin
                if (rd) begin
                    rv = {13'd0, m_sticky, m_lock, m_pend};
                    stat_rd = 1;
                end else err = 1;
            end else if (ki >= 0) begin
                if (rd) rv = m_sh[ki];
                else if (m_lock) err = 1;
                else begin
                    m_sh[ki] = d;
`ifndef CIPHER_KEY_REGFILE_SHADOW_EN
                    m_act[ki] = d;
`endif
                end
            end else err = 1;
        end
`ifdef CIPHER_KEY_REGFILE_SHADOW_EN
        if (m_pend && !busy) begin
            m_act = old_sh;
            m_sel_act = old_sel;
            m_pend = 0;
            m_cd = 1;
        end else begin
            m_cd = 0;
            if (req) m_pend = 1;
        end
`else
        m_cd = req & 1'b0;
`endif
        m_done = rd | wr;
        m_err = err;
        if (rd) m_rdata = err ? 16'h0 : rv;
        if (err) m_sticky = 1;
        else if (stat_rd) m_sticky = 0;
    endtask

    task automatic check_outputs();
        chk("done", done, m_done);
        chk("error", error, m_err);
        chk("rdata", rdata, m_rdata);
        chk("commit_done", commit_done, m_cd);
        chk("select", select, 16'(m_sel_act));
        chk("keys", keys, {m_act[2], m_act[1], m_act[0]});
    endtask

    task automatic cycle(input bit rd, input bit wr, input int a,
                         input logic [15:0] d, input bit busy);
        read = rd; write = wr; addr = 8'(a); wdata = d;
        core_busy = busy;
        model_edge(rd, wr, a, d, busy);
        @(posedge clk);
        #1;
        read = 0; write = 0;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 0; read = 0; write = 0; core_busy = 0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1;
    endtask

    initial begin
        int r, a;
        bit rd, wr, busy;
        logic [15:0] d;

        do_reset();
        chk("reset_keys", keys, 48'h0002_FFFF_0000);

        cycle(1, 0, 'h12, 0, 0);
        chk("key1_read", rdata, 16'hFFFF);

        cycle(0, 1, 'h10, 16'h0005, 0);
        cycle(0, 1, 'h02, 16'h0001, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        cycle(0, 1, 'h12, 16'h1234, 1);
        cycle(0, 1, 'h02, 16'h0001, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 'h04, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        cycle(0, 1, 'h00, 16'h0003, 0);
        chk("sel3_err", error, 1'b1);
        cycle(1, 0, 'h04, 0, 0);
        chk("sticky_set", rdata[2], 1'b1);
        cycle(1, 0, 'h04, 0, 0);
        chk("sticky_clr", rdata[2], 1'b0);

        cycle(0, 1, 'h02, 16'h0002, 0);
        cycle(0, 1, 'h14, 16'h0007, 0);
        chk("locked_key_err", error, 1'b1);
        cycle(1, 0, 'h14, 0, 0);
        cycle(1, 0, 'h04, 0, 0);
        cycle(1, 0, 'h04, 0, 0);
        chk("status_locked", rdata, 16'h0002);

        cycle(1, 1, 'h00, 16'h0001, 0);
        cycle(1, 0, 'h06, 0, 0);
        chk("bad_addr_err", error, 1'b1);

        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
                continue;
            end
            case ($urandom_range(0, 7))
                0: a = 'h00;
                1: a = 'h02;
                2: a = 'h04;
                3: a = 'h10;
                4: a = 'h12;
                5: a = 'h14;
                6: a = 'h06;
                default: a = int'($urandom_range(0, 255));
            endcase
            r = int'($urandom_range(0, 9));
            rd = (r <= 3) || (r == 8);
            wr = (r >= 4 && r <= 8);
            if (a == 'h00) d = 16'($urandom_range(0, 4));
            else if (a == 'h02) d = ($urandom_range(0, 7) == 0) ?
                                    16'h0003 : 16'h0001;
            else d = 16'($urandom);
            busy = ($urandom_range(0, 2) == 0);
            cycle(rd, wr, a, d, busy);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
